// File: rtl/keccak_round_ctrl_if.sv
// Round-constant table and iota lane bus for keccak_round_ctrl.
// master is the permutation/table side, slave is the round controller.
interface keccak_round_ctrl_if;
  logic [4:0]  lut_addr;
  logic [63:0] lut_q;
  logic [63:0] lane_in;
  logic        lane_valid;
  logic        lane_ready;
  logic [63:0] lane_out;
  logic        lane_out_valid;

  modport master (
    output lut_q,
    output lane_in,
    output lane_valid,
    input  lut_addr,
    input  lane_ready,
    input  lane_out,
    input  lane_out_valid
  );

  modport slave (
    input  lut_q,
    input  lane_in,
    input  lane_valid,
    output lut_addr,
    output lane_ready,
    output lane_out,
    output lane_out_valid
  );
endinterface

// File: rtl/keccak_round_ctrl.sv
// Keccak-f[1600] round sequencer and iota stage.
// Steps rounds 0..NR-1 and XORs each round constant into A[0][0].
module keccak_round_ctrl #(
  parameter int NR      = 24,
  parameter int LUT_LAT = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic [4:0]         round_idx,
  output logic               busy,
  output logic               done,
  keccak_round_ctrl_if.slave bus
);

  localparam int CW = (LUT_LAT > 1) ? $clog2(LUT_LAT + 1) : 1;
  localparam logic [4:0]    LAST = 5'(NR - 1);
  localparam logic [CW-1:0] LAT  = CW'(LUT_LAT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_WAIT,
    S_FINISH
  } state_t;

  state_t        state, state_n;
  logic [4:0]    round_q, round_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [63:0]   out_q, out_n;
  logic          lov_q, lov_n;
  logic          done_q, done_n;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      round_q <= '0;
      cnt     <= '0;
      out_q   <= '0;
      lov_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state   <= state_n;
      round_q <= round_n;
      cnt     <= cnt_n;
      out_q   <= out_n;
      lov_q   <= lov_n;
      done_q  <= done_n;
    end
  end

  always_comb begin
    state_n = state;
    round_n = round_q;
    cnt_n   = cnt;
    out_n   = out_q;
    lov_n   = 1'b0;
    done_n  = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          state_n = S_SETTLE;
          round_n = '0;
          cnt_n   = LAT;
        end
      end
      S_SETTLE: begin
        // Saturating so a zero-latency table still costs one cycle
        cnt_n = (cnt == '0) ? '0 : cnt - CW'(1);
        if (cnt <= CW'(1)) state_n = S_WAIT;
      end
      S_WAIT: begin
        if (bus.lane_valid) begin
          out_n = bus.lane_in ^ bus.lut_q;
          lov_n = 1'b1;
          if (round_q == LAST) begin
            state_n = S_FINISH;
          end else begin
            round_n = round_q + 5'd1;
            cnt_n   = LAT;
            state_n = S_SETTLE;
          end
        end
      end
      S_FINISH: begin
        done_n  = 1'b1;
        round_n = '0;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  assign bus.lut_addr       = round_q;
  assign bus.lane_ready     = (state == S_WAIT);
  assign bus.lane_out       = out_q;
  assign bus.lane_out_valid = lov_q;
  assign round_idx          = round_q;
  assign busy               = (state != S_IDLE);
  assign done               = done_q;

endmodule

// File: doc/keccak_round_ctrl.md
Name: keccak_round_ctrl

Overview:
- Round sequencer and iota stage for the Keccak-f[1600] permutation.
- Drives the address of the 24-entry round-constant table (synchronous read, registered 64-bit output, 1-cycle latency) and consumes the constant it returns.
- XORs that constant into lane A[0][0] after the chi step, once per round, and counts rounds 0..NR-1 under a start/done handshake with the permutation top level.

Parameters:
- NR, 24, number of rounds. Also the table depth used; must be ≤ 32.
- LUT_LAT, 1, cycles from a lut_addr change until lut_q is valid.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request to begin a permutation; honoured only in IDLE.
- lut_addr  output  5  round-constant table address; equals the current round index.
- lut_q  input  64  round constant returned by the table.
- lane_in  input  64  A[0][0] after chi for the current round.
- lane_valid  input  1  lane_in valid; held by the source until accepted.
- lane_ready  output  1  block can accept lane_in this cycle.
- lane_out  output  64  lane_in ^ lut_q, registered.
- lane_out_valid  output  1  one-cycle pulse qualifying lane_out.
- round_idx  output  5  current round, 0..NR-1.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse after the last round's iota.

Behaviour:
- Reset (rst=0, async) forces state=IDLE. Output values in reset:
  - lut_addr=0, round_idx=0, lane_out=0
  - lane_out_valid=0, done=0, lane_ready=0, busy=0
  - settle counter=0
- Reset mid-permutation abandons the permutation; no done pulse is produced.
- States:
  - IDLE:
    - start=1 → SETTLE; round_idx=0; settle counter loaded with LUT_LAT.
    - start=0 → stay in IDLE.
  - SETTLE:
    - settle counter decrements each cycle.
    - Counter reaching 0 → WAIT.
    - lut_addr is held stable throughout.
  - WAIT:
    - lane_ready=1 (combinational from state).
    - On lane_valid & lane_ready:
      - lane_out <= lane_in ^ lut_q; lane_out_valid pulses for the next cycle.
      - If round_idx==NR-1: go to FINISH.
      - Otherwise: round_idx and lut_addr increment, counter reloads with LUT_LAT, go to SETTLE.
  - FINISH:
    - done=1 for exactly one cycle; round_idx and lut_addr return to 0.
    - Next state is IDLE.
- lut_addr == round_idx at all times (registered). It changes only on the transition out of WAIT or into IDLE.
- Per-round throughput: 1 + LUT_LAT cycles minimum. A full permutation with lane_valid tied high takes 1 + NR·(LUT_LAT+1) + 1 cycles from the start edge to done.
- start while busy=1 is ignored: no restart, no effect on round_idx.
- start in the same cycle that FINISH returns to IDLE is not sampled. start must be asserted again once in IDLE.
- lane_valid outside WAIT is not accepted: lane_ready=0 and no state change. The source keeps lane_valid and lane_in stable.
- lane_out holds its last value between pulses. Only lane_out_valid qualifies it.
- No arithmetic beyond the 64-bit XOR and a 5-bit round counter. The counter never reaches NR, so there is no wrap.

Test Plan:
- Reset/idle: assert rst=0 mid-run at round 5 → all outputs 0 within the same cycle, state IDLE; release, no done pulse; restart runs a full 24 rounds.
- Single permutation, lane_in=0, lane_valid=1 constantly → exactly 24 lane_out_valid pulses, with:
  - round 0 lane_out=0x0000000000000001
  - round 1 lane_out=0x0000000000008082
  - round 23 lane_out=0x8000000080008008
  - done pulse one cycle after the 24th pulse; total 50 cycles start→done.
- Iota XOR: lane_in=0xFFFFFFFFFFFFFFFF on round 2 → lane_out=0x7FFFFFFFFFFF7F75.
- Backpressure: lane_valid delayed 3 cycles in round 7 → lane_ready stays 1, lut_addr stays 7, no pulse until lane_valid rises; lane_out=lane_in^0x8000000000008009.
- Protocol abuse:
  - start pulsed at round 10 → ignored, rounds continue 11..23.
  - lane_valid high during SETTLE → not accepted, lane_ready=0.
- Back-to-back: start asserted the cycle after done → a second permutation completes with an identical constant sequence.
